parking_gate_ctrl: RTL

// - Event source for the occupancy counter: runs entry and exit barrier gates, classifies each car as uni or general.
// - Emits one-cycle car_entered / car_exited pulses with type flags, and consumes the counter's vacancy flags.
// - Sits between the lane sensors and card readers on one side and the parking occupancy counter on the other.

---
 rtl/parking_pkg.sv | 31 +++
 rtl/parking_gate_ctrl_if.sv | 37 +++
 rtl/parking_debounce.sv | 44 ++++
 rtl/parking_gate_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and default constants for the parking gate controller.
// Lane FSM states, lane identifiers and the round-robin helper live here.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    OPEN   = 3'd2,
    DENY   = 3'd3,
    REPORT = 3'd4,
    CLEAR  = 3'd5
  } gate_state_t;

  typedef enum logic {
    ENTRY = 1'b0,
    EXIT  = 1'b1
  } lane_t;

  localparam int DEBOUNCE_CYCLES = 4;
  localparam int PASS_TIMEOUT    = 64;
  localparam int TMR_W           = 8;

  function automatic lane_t other_lane(input lane_t lane);
    if (lane == ENTRY) begin
      return EXIT;
    end else begin
      return ENTRY;
    end
  endfunction

endpackage

// File: rtl/parking_gate_ctrl_if.sv
// Sensor, card-reader, vacancy and event signals of the parking gate controller.
// master = lane hardware / counter side, slave = the controller.
interface parking_gate_ctrl_if;

  logic entry_loop;
  logic entry_is_uni;
  logic entry_pass;
  logic exit_loop;
  logic exit_is_uni;
  logic exit_pass;
  logic uni_is_vacated_space;
  logic is_vacated_space;
  logic entry_gate_open;
  logic exit_gate_open;
  logic entry_denied;
  logic car_entered;
  logic is_uni_car_entered;
  logic car_exited;
  logic is_uni_car_exited;

  modport master (
    output entry_loop, entry_is_uni, entry_pass,
    output exit_loop, exit_is_uni, exit_pass,
    output uni_is_vacated_space, is_vacated_space,
    input  entry_gate_open, exit_gate_open, entry_denied,
    input  car_entered, is_uni_car_entered, car_exited, is_uni_car_exited
  );

  modport slave (
    input  entry_loop, entry_is_uni, entry_pass,
    input  exit_loop, exit_is_uni, exit_pass,
    input  uni_is_vacated_space, is_vacated_space,
    output entry_gate_open, exit_gate_open, entry_denied,
    output car_entered, is_uni_car_entered, car_exited, is_uni_car_exited
  );

endinterface

// File: rtl/parking_debounce.sv
// Sensor debouncer: the level follows the raw input only after DEBOUNCE_CYCLES
// identical consecutive samples; rise strobes for one cycle on an accepted 0->1.
module parking_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             level_r;
  logic             rise_r;

  // count consecutive samples that disagree with the accepted level
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r   <= '0;
      level_r <= 1'b0;
      rise_r  <= 1'b0;
    end else if (raw == level_r) begin
      cnt_r   <= '0;
      level_r <= level_r;
      rise_r  <= 1'b0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r   <= '0;
      level_r <= raw;
      rise_r  <= raw;
    end else begin
      cnt_r   <= cnt_r + CNT_W'(1);
      level_r <= level_r;
      rise_r  <= 1'b0;
    end
  end

  assign level = level_r;
  assign rise  = rise_r;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Entry/exit barrier controller: one FSM per lane plus a round-robin arbiter
// that serialises car_entered / car_exited pulses towards the occupancy counter.
module parking_gate_ctrl #(
  parameter int DEBOUNCE_CYCLES = parking_pkg::DEBOUNCE_CYCLES,
  parameter int PASS_TIMEOUT    = parking_pkg::PASS_TIMEOUT,
  parameter int TMR_W           = parking_pkg::TMR_W
) (
  input  logic               clk,
  input  logic               reset,
  parking_gate_ctrl_if.slave bus
);

  import parking_pkg::*;

  logic [1:0] loop_raw_s;
  logic [1:0] pass_raw_s;
  logic [1:0] is_uni_s;
  logic [1:0] vac_ok_s;
  logic [1:0] req_s;
  logic [1:0] typ_s;
  logic [1:0] grant_s;
  logic       busy_s;
  logic       tie_s;
  lane_t      rr_last_r;
  logic       car_entered_r;
  logic       uni_entered_r;
  logic       car_exited_r;
  logic       uni_exited_r;

  assign loop_raw_s = {bus.exit_loop, bus.entry_loop};
  assign pass_raw_s = {bus.exit_pass, bus.entry_pass};
  assign is_uni_s   = {bus.exit_is_uni, bus.entry_is_uni};
  // the exit lane never checks vacancy
  assign vac_ok_s   = {1'b1, bus.entry_is_uni ? bus.uni_is_vacated_space : bus.is_vacated_space};

  for (genvar g = int'(ENTRY); g <= int'(EXIT); g++) begin : g_lane
    gate_state_t      state_r;
    gate_state_t      state_nxt_s;
    logic [TMR_W-1:0] timer_r;
    logic             typ_r;
    logic             gate_r;
    logic             loop_lvl_s;
    logic             loop_rise_s;
    logic             pass_lvl_s;
    logic             pass_rise_s;

    parking_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_loop_db (
      .clk   (clk),
      .reset (reset),
      .raw   (loop_raw_s[g]),
      .level (loop_lvl_s),
      .rise  (loop_rise_s)
    );

    parking_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pass_db (
      .clk   (clk),
      .reset (reset),
      .raw   (pass_raw_s[g]),
      .level (pass_lvl_s),
      .rise  (pass_rise_s)
    );

    // lane next-state logic
    always_comb begin
      state_nxt_s = state_r;
      case (state_r)
        IDLE:   if (loop_rise_s) state_nxt_s = CHECK; else state_nxt_s = IDLE;
        CHECK:  if (vac_ok_s[g]) state_nxt_s = OPEN; else state_nxt_s = DENY;
        OPEN: begin
          if (pass_rise_s) begin
            state_nxt_s = REPORT;
          end else if (timer_r == TMR_W'(PASS_TIMEOUT - 1)) begin
            state_nxt_s = CLEAR;
          end else begin
            state_nxt_s = OPEN;
          end
        end
        REPORT: if (grant_s[g]) state_nxt_s = CLEAR; else state_nxt_s = REPORT;
        DENY:   if (!loop_lvl_s) state_nxt_s = IDLE; else state_nxt_s = DENY;
        CLEAR:  if (!loop_lvl_s && !pass_lvl_s) state_nxt_s = IDLE; else state_nxt_s = CLEAR;
        default: state_nxt_s = IDLE;
      endcase
    end

    // lane state, open timer, latched class and gate drive
    always_ff @(posedge clk) begin
      if (reset) begin
        state_r <= IDLE;
        timer_r <= '0;
        typ_r   <= 1'b0;
        gate_r  <= 1'b0;
      end else begin
        state_r <= state_nxt_s;
        timer_r <= ((state_r == OPEN) && (state_nxt_s == OPEN)) ? timer_r + TMR_W'(1) : '0;
        typ_r   <= (state_r == CHECK) ? is_uni_s[g] : typ_r;
        gate_r  <= (state_nxt_s == OPEN) || (state_nxt_s == REPORT);
      end
    end

    assign req_s[g] = (state_r == REPORT);
    assign typ_s[g] = typ_r;

    if (g == int'(ENTRY)) begin : g_entry_out
      logic deny_r;

      // FULL lamp follows the entry lane's DENY state
      always_ff @(posedge clk) begin
        if (reset) begin
          deny_r <= 1'b0;
        end else begin
          deny_r <= (state_nxt_s == DENY);
        end
      end

      assign bus.entry_gate_open = gate_r;
      assign bus.entry_denied    = deny_r;
    end else begin : g_exit_out
      assign bus.exit_gate_open = gate_r;
    end
  end

  // a pulse in flight blocks new grants, guaranteeing an idle cycle between pulses
  assign busy_s = car_entered_r | car_exited_r;
  assign tie_s  = (req_s == 2'b11) && !busy_s;

  // arbiter grant selection
  always_comb begin
    grant_s = 2'b00;
    if (busy_s) begin
      grant_s = 2'b00;
    end else if (req_s == 2'b11) begin
      grant_s = (rr_last_r == ENTRY) ? 2'b10 : 2'b01;
    end else begin
      grant_s = req_s;
    end
  end

  // event pulses, class qualifiers and tie history
  always_ff @(posedge clk) begin
    if (reset) begin
      car_entered_r <= 1'b0;
      uni_entered_r <= 1'b0;
      car_exited_r  <= 1'b0;
      uni_exited_r  <= 1'b0;
      rr_last_r     <= ENTRY;
    end else begin
      car_entered_r <= grant_s[ENTRY];
      uni_entered_r <= grant_s[ENTRY] & typ_s[ENTRY];
      car_exited_r  <= grant_s[EXIT];
      uni_exited_r  <= grant_s[EXIT] & typ_s[EXIT];
      if (tie_s) begin
        rr_last_r <= other_lane(rr_last_r);
      end else begin
        rr_last_r <= rr_last_r;
      end
    end
  end

  assign bus.car_entered        = car_entered_r;
  assign bus.is_uni_car_entered = uni_entered_r;
  assign bus.car_exited         = car_exited_r;
  assign bus.is_uni_car_exited  = uni_exited_r;

endmodule
